// File: rtl/exc_commit_ctrl.sv
// Registered exception/interrupt commit controller: prioritises one committing
// instruction's events into a MIPS ExcCode, pulses the CP0 update, then flushes and redirects fetch.
module exc_commit_ctrl #(
  parameter int          HW_INT_NUM   = 6,
  parameter int          SYNC_STAGES  = 2,
  parameter int          FLUSH_CYCLES = 2,
  parameter logic [31:0] EXC_VECTOR   = 32'hbfc0_0380
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [HW_INT_NUM-1:0] hw_int,
  input  logic                  commit_valid,
  output logic                  commit_ready,
  input  logic [7:0]            exc_flags,
  input  logic                  laddr_err,
  input  logic                  saddr_err,
  input  logic [31:0]           commit_pc,
  input  logic                  commit_bd,
  input  logic [31:0]           commit_badaddr,
  input  logic [31:0]           cp0_status,
  input  logic [31:0]           cp0_cause,
  input  logic [31:0]           cp0_epc,
  output logic [HW_INT_NUM-1:0] ip_sync,
  output logic                  exc_valid,
  output logic [4:0]            exc_code,
  output logic [31:0]           exc_epc,
  output logic                  exc_bd,
  output logic                  exc_badvaddr_we,
  output logic [31:0]           exc_badvaddr,
  output logic                  eret_valid,
  output logic                  flush,
  output logic                  redirect_valid,
  output logic [31:0]           redirect_pc,
  input  logic                  redirect_ready
);

  typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_WAIT} state_e;

  state_e state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0][HW_INT_NUM-1:0] sync_q, sync_d;
  logic        exc_valid_q, exc_valid_d, eret_valid_q, eret_valid_d;
  logic [4:0]  exc_code_q, exc_code_d;
  logic [31:0] exc_epc_q, exc_epc_d, exc_bad_q, exc_bad_d, rpc_q, rpc_d;
  logic        exc_bd_q, exc_bd_d, exc_bwe_q, exc_bwe_d, rv_q, rv_d;

  logic [5:0]  ip6;
  logic        int_req, accept, take_exc, take_eret, bwe, hs;
  logic [4:0]  code;
  logic [31:0] bad;
  logic        unused_ok;

  assign unused_ok = ^{cp0_status[31:16], cp0_status[7:2], cp0_cause[31:10],
                       cp0_cause[7:0], exc_flags[1:0]};

  // Stage 0 captures the raw line; the last stage is the only one used.
  assign sync_d  = {sync_q[SYNC_STAGES-2:0], hw_int};
  assign ip_sync = sync_q[SYNC_STAGES-1];

  always_comb begin
    ip6 = '0;
    ip6[HW_INT_NUM-1:0] = ip_sync;
  end

  assign int_req = (({ip6, cp0_cause[9:8]} & cp0_status[15:8]) != 8'd0)
                   && !cp0_status[1] && cp0_status[0];
  assign commit_ready = (state_q == S_IDLE);
  assign flush        = (state_q == S_FLUSH);
  assign accept       = commit_valid && commit_ready;
  assign hs           = rv_q && redirect_ready;

  always_comb begin
    take_exc = 1'b1;
    bwe      = 1'b0;
    bad      = commit_badaddr;
    code     = 5'h00;
    if (int_req)                       code = 5'h00;
    else if (exc_flags[7] || laddr_err) begin
      code = 5'h04;
      bwe  = 1'b1;
      if (exc_flags[7]) bad = commit_pc;
    end
    else if (saddr_err)    begin code = 5'h05; bwe = 1'b1; end
    else if (exc_flags[6]) code = 5'h08;
    else if (exc_flags[5]) code = 5'h09;
    else if (exc_flags[3]) code = 5'h0a;
    else if (exc_flags[2]) code = 5'h0c;
    else                   take_exc = 1'b0;
  end

  assign take_eret = !take_exc && exc_flags[4];

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    exc_valid_d  = 1'b0;
    eret_valid_d = 1'b0;
    exc_bwe_d    = 1'b0;
    exc_code_d   = exc_code_q;
    exc_epc_d    = exc_epc_q;
    exc_bd_d     = exc_bd_q;
    exc_bad_d    = exc_bad_q;
    rv_d         = hs ? 1'b0 : rv_q;
    rpc_d        = rpc_q;
    case (state_q)
      S_IDLE: begin
        if (accept && (take_exc || take_eret)) begin
          state_d = S_FLUSH;
          cnt_d   = 3'(FLUSH_CYCLES - 1);
          rv_d    = 1'b1;
          if (take_exc) begin
            exc_valid_d = 1'b1;
            exc_code_d  = code;
            exc_epc_d   = commit_bd ? commit_pc - 32'd4 : commit_pc;
            exc_bd_d    = commit_bd;
            exc_bwe_d   = bwe;
            exc_bad_d   = bad;
            rpc_d       = EXC_VECTOR;
          end else begin
            eret_valid_d = 1'b1;
            rpc_d        = cp0_epc;
          end
        end
      end
      S_FLUSH: begin
        if (cnt_q == 3'd0) state_d = (rv_q && !redirect_ready) ? S_WAIT : S_IDLE;
        else               cnt_d   = cnt_q - 3'd1;
      end
      S_WAIT:  if (hs) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      sync_q       <= '0;
      exc_valid_q  <= 1'b0;
      eret_valid_q <= 1'b0;
      exc_code_q   <= '0;
      exc_epc_q    <= '0;
      exc_bd_q     <= 1'b0;
      exc_bwe_q    <= 1'b0;
      exc_bad_q    <= '0;
      rv_q         <= 1'b0;
      rpc_q        <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sync_q       <= sync_d;
      exc_valid_q  <= exc_valid_d;
      eret_valid_q <= eret_valid_d;
      exc_code_q   <= exc_code_d;
      exc_epc_q    <= exc_epc_d;
      exc_bd_q     <= exc_bd_d;
      exc_bwe_q    <= exc_bwe_d;
      exc_bad_q    <= exc_bad_d;
      rv_q         <= rv_d;
      rpc_q        <= rpc_d;
    end
  end

  assign exc_valid       = exc_valid_q;
  assign eret_valid      = eret_valid_q;
  assign exc_code        = exc_code_q;
  assign exc_epc         = exc_epc_q;
  assign exc_bd          = exc_bd_q;
  assign exc_badvaddr_we = exc_bwe_q;
  assign exc_badvaddr    = exc_bad_q;
  assign redirect_valid  = rv_q;
  assign redirect_pc     = rpc_q;

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Scoreboard bench for exc_commit_ctrl: directed plan cases plus randomized commits
// checked against a priority-list reference model.
module tb_exc_commit_ctrl;
  localparam int FC = 2;
  localparam logic [31:0] VEC = 32'hbfc0_0380;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [5:0]  hw_int = '0;
  logic        commit_valid = 0, commit_ready, laddr_err = 0, saddr_err = 0, commit_bd = 0;
  logic [7:0]  exc_flags = '0;
  logic [31:0] commit_pc = '0, commit_badaddr = '0, cp0_status = '0, cp0_cause = '0, cp0_epc = '0;
  logic [5:0]  ip_sync;
  logic        exc_valid, exc_bd, exc_badvaddr_we, eret_valid, flush, redirect_valid;
  logic        redirect_ready = 0;
  logic [4:0]  exc_code;
  logic [31:0] exc_epc, exc_badvaddr, redirect_pc;

  exc_commit_ctrl #(.HW_INT_NUM(6), .SYNC_STAGES(2), .FLUSH_CYCLES(FC), .EXC_VECTOR(VEC)) dut (
    .clk(clk), .rst_n(rst_n), .hw_int(hw_int), .commit_valid(commit_valid),
    .commit_ready(commit_ready), .exc_flags(exc_flags), .laddr_err(laddr_err),
    .saddr_err(saddr_err), .commit_pc(commit_pc), .commit_bd(commit_bd),
    .commit_badaddr(commit_badaddr), .cp0_status(cp0_status), .cp0_cause(cp0_cause),
    .cp0_epc(cp0_epc), .ip_sync(ip_sync), .exc_valid(exc_valid), .exc_code(exc_code),
    .exc_epc(exc_epc), .exc_bd(exc_bd), .exc_badvaddr_we(exc_badvaddr_we),
    .exc_badvaddr(exc_badvaddr), .eret_valid(eret_valid), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .redirect_ready(redirect_ready));

  typedef struct {
    logic        eret;
    logic [4:0]  code;
    logic [31:0] epc;
    logic        bd;
    logic        bwe;
    logic [31:0] bad;
    logic [31:0] rpc;
  } exp_t;

  exp_t sbq[$];
  int checks = 0, errors = 0;
  int rr_mode = 0;  // 0 random, 1 held low, 2 held high

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Spec priority list applied to a single commit; returns 0 for a plain commit.
  function automatic bit model(input logic [7:0] f, input bit la, input bit sa,
                               input logic [31:0] pc, input bit bd, input logic [31:0] bd_addr,
                               input logic [31:0] epc, input logic [5:0] hw,
                               input logic [31:0] st, input logic [31:0] ca, output exp_t e);
    bit intp;
    intp = ((({hw, ca[9:8]}) & st[15:8]) != 8'd0) && !st[1] && st[0];
    e.eret = 0; e.code = 0; e.bwe = 0; e.bad = 0;
    e.epc = bd ? pc - 32'd4 : pc;
    e.bd  = bd;
    e.rpc = VEC;
    if (intp)              e.code = 5'h00;
    else if (f[7] || la) begin e.code = 5'h04; e.bwe = 1; e.bad = f[7] ? pc : bd_addr; end
    else if (sa)         begin e.code = 5'h05; e.bwe = 1; e.bad = bd_addr; end
    else if (f[6])         e.code = 5'h08;
    else if (f[5])         e.code = 5'h09;
    else if (f[3])         e.code = 5'h0a;
    else if (f[2])         e.code = 5'h0c;
    else if (f[4])       begin e.eret = 1; e.rpc = epc; end
    else return 0;
    return 1;
  endfunction

  // Waits for commit_ready, offers one commit for one cycle; returns on the next negedge.
  task automatic issue(input logic [7:0] f, input bit la, input bit sa, input logic [31:0] pc,
                       input bit bd, input logic [31:0] bad, input logic [31:0] epc, output bit ev);
    exp_t e;
    int w = 0;
    ev = 0;
    while (!commit_ready && w < 60) begin @(negedge clk); w++; end
    if (!commit_ready) begin
      checks++; errors++;
      $display("FAIL ready_timeout got=0 want=1 t=%0t", $time);
      return;
    end
    exc_flags = f; laddr_err = la; saddr_err = sa; commit_pc = pc;
    commit_bd = bd; commit_badaddr = bad; cp0_epc = epc; commit_valid = 1;
    ev = model(f, la, sa, pc, bd, bad, epc, hw_int, cp0_status, cp0_cause, e);
    if (ev) sbq.push_back(e);
    @(negedge clk);
    commit_valid = 0; exc_flags = 0; laddr_err = 0; saddr_err = 0;
  endtask

  initial forever begin
    @(negedge clk);
    #1;
    case (rr_mode)
      1:       redirect_ready = 0;
      2:       redirect_ready = 1;
      default: redirect_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: pops on every CP0 pulse, tracks flush length and redirect_pc stability.
  initial begin
    exp_t e;
    int flen = 0;
    bit prev_rv = 0;
    logic [31:0] prev_rpc = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin flen = 0; prev_rv = 0; continue; end
      if (exc_valid || eret_valid) begin
        if (sbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_pulse got exc=%b eret=%b want none t=%0t", exc_valid, eret_valid, $time);
        end else begin
          e = sbq.pop_front();
          chk("eret_valid", 32'(eret_valid), 32'(e.eret));
          chk("exc_valid", 32'(exc_valid), 32'(!e.eret));
          chk("redirect_valid", 32'(redirect_valid), 1);
          chk("redirect_pc", redirect_pc, e.rpc);
          chk("flush_with_pulse", 32'(flush), 1);
          if (!e.eret) begin
            chk("exc_code", 32'(exc_code), 32'(e.code));
            chk("exc_epc", exc_epc, e.epc);
            chk("exc_bd", 32'(exc_bd), 32'(e.bd));
            chk("badvaddr_we", 32'(exc_badvaddr_we), 32'(e.bwe));
            if (e.bwe) chk("badvaddr", exc_badvaddr, e.bad);
          end
        end
      end
      if (flush) begin
        flen++;
        chk("ready_in_flush", 32'(commit_ready), 0);
      end else if (flen != 0) begin
        chk("flush_len", flen, FC);
        flen = 0;
      end
      if (redirect_valid && prev_rv) chk("rpc_stable", redirect_pc, prev_rpc);
      prev_rv = redirect_valid;
      prev_rpc = redirect_pc;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    bit ev;
    int n;
    #1;
    chk("rst_ready", 32'(commit_ready), 1);
    chk("rst_flush", 32'(flush), 0);
    chk("rst_exc_valid", 32'(exc_valid), 0);
    chk("rst_eret_valid", 32'(eret_valid), 0);
    chk("rst_redirect_valid", 32'(redirect_valid), 0);
    chk("rst_redirect_pc", redirect_pc, 0);
    chk("rst_ip_sync", 32'(ip_sync), 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    // Syscall, then delay-slot load error.
    issue(8'h40, 0, 0, 32'hbfc0_1000, 0, 0, 0, ev);
    issue(8'h00, 1, 0, 32'h8000_0104, 1, 32'h0000_0003, 0, ev);

    // Interrupt beats overflow; masked by EXL it does not.
    hw_int = 6'h01; cp0_status = 32'h0000_0401;
    repeat (4) @(negedge clk);
    chk("ip_sync_follow", 32'(ip_sync), 32'h01);
    issue(8'h04, 0, 0, 32'h8000_0200, 0, 0, 0, ev);
    cp0_status = 32'h0000_0403;
    issue(8'h04, 0, 0, 32'h8000_0204, 0, 0, 0, ev);
    hw_int = 0; cp0_status = 0;

    // ERET.
    issue(8'h10, 0, 0, 32'h8000_0300, 0, 0, 32'hbfc0_2000, ev);

    // Backpressure: redirect held off, WAIT ignores commits.
    while (!commit_ready) @(negedge clk);
    rr_mode = 1;
    @(negedge clk);
    issue(8'h40, 0, 0, 32'h8000_0400, 0, 0, 0, ev);
    for (int i = 0; i < 5; i++) begin
      chk("bp_ready_low", 32'(commit_ready), 0);
      commit_valid = (i == 2);
      exc_flags = (i == 2) ? 8'h40 : 8'h00;
      @(negedge clk);
    end
    commit_valid = 0; exc_flags = 0;
    chk("bp_wait_noflush", 32'(flush), 0);
    chk("bp_rv_held", 32'(redirect_valid), 1);
    rr_mode = 2;
    @(negedge clk);
    chk("bp_ready_back", 32'(commit_ready), 1);
    chk("bp_rv_drop", 32'(redirect_valid), 0);
    rr_mode = 0;

    // Randomized commits under random interrupt/status setup.
    for (int t = 0; t < 60; t++) begin
      logic [7:0] f;
      hw_int = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'h0;
      cp0_status = {16'h0, 8'($urandom), 6'h0, 1'($urandom_range(0, 3) == 0), 1'($urandom)};
      cp0_cause = {22'h0, 2'($urandom), 8'h0};
      repeat (4) @(negedge clk);
      f = ($urandom_range(0, 3) == 0) ? 8'h00 : (8'($urandom) & 8'hfc);
      issue(f, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
            {$urandom, 2'b00} , 1'($urandom), $urandom, {$urandom, 2'b00}, ev);
      if (!ev) chk("plain_commit_ready", 32'(commit_ready), 1);
    end
    hw_int = 0; cp0_status = 0; cp0_cause = 0;

    // Reset in the middle of a flush.
    issue(8'h40, 0, 0, 32'hbfc0_1000, 0, 0, 0, ev);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_flush", 32'(flush), 0);
    chk("mid_rst_rv", 32'(redirect_valid), 0);
    chk("mid_rst_exc_valid", 32'(exc_valid), 0);
    chk("mid_rst_ready", 32'(commit_ready), 1);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("post_rst_ready", 32'(commit_ready), 1);
    chk("post_rst_flush", 32'(flush), 0);

    n = 0;
    while (!commit_ready && n < 50) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    chk("sb_drained", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
